cdb_broadcast_arbiter: RTL and testbench

Transmitter side of the common data bus (CDB). Functional units hand completed results (tag + data) to this block through valid/ready handshakes. Each source has a small per-source FIFO. The block picks one queued result per cycle with round-robin priority and drives it onto the registered CDB outputs, which feed top-level result observers and the uo_out pins.

---
 rtl/cdb_broadcast_arbiter.sv | 157 +++++++++++++++
 tb/tb_cdb_broadcast_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_broadcast_arbiter.sv
// CDB transmitter: per-source result FIFOs feeding a round-robin arbiter
// that drives one registered broadcast (tag, data, source) per cycle.
module cdb_broadcast_arbiter #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned TAG_W   = 3,
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned DEPTH   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic [NUM_SRC-1:0]           src_valid,
    output logic [NUM_SRC-1:0]           src_ready,
    input  logic [NUM_SRC*TAG_W-1:0]     src_tag,
    input  logic [NUM_SRC*DATA_W-1:0]    src_data,
    output logic                         cdb_valid,
    output logic [TAG_W-1:0]             cdb_tag,
    output logic [DATA_W-1:0]            cdb_data,
    output logic [$clog2(NUM_SRC)-1:0]   cdb_src
);

    localparam int unsigned SRC_W = $clog2(NUM_SRC);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // FIFO storage and bookkeeping, one set per source
    logic [TAG_W-1:0]  mem_tag_q  [NUM_SRC][DEPTH];
    logic [TAG_W-1:0]  mem_tag_d  [NUM_SRC][DEPTH];
    logic [DATA_W-1:0] mem_data_q [NUM_SRC][DEPTH];
    logic [DATA_W-1:0] mem_data_d [NUM_SRC][DEPTH];
    logic [PTR_W-1:0]  wptr_q [NUM_SRC];
    logic [PTR_W-1:0]  wptr_d [NUM_SRC];
    logic [PTR_W-1:0]  rptr_q [NUM_SRC];
    logic [PTR_W-1:0]  rptr_d [NUM_SRC];
    logic [CNT_W-1:0]  cnt_q  [NUM_SRC];
    logic [CNT_W-1:0]  cnt_d  [NUM_SRC];

    // Arbitration pointer and broadcast register
    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;

    logic              grant_vld;
    logic [SRC_W-1:0]  grant_idx;

    // Ready depends only on the registered occupancy
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ready[i] = (cnt_q[i] < CNT_W'(DEPTH));
        end
    end

    // Round-robin pick: scan from rr_ptr upward; descending loop lets the nearest candidate win
    always_comb begin
        logic [SRC_W-1:0] idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = SRC_W'((32'(rr_ptr_q) + 32'(k)) % NUM_SRC);
            if (cnt_q[idx] != '0) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
    end

    // Next-state: pushes, pop of the granted head, broadcast register, flush
    always_comb begin
        logic push;
        logic pop;
        mem_tag_d   = mem_tag_q;
        mem_data_d  = mem_data_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        cdb_tag_d   = '0;
        cdb_data_d  = '0;
        cdb_src_d   = '0;
        push        = 1'b0;
        pop         = 1'b0;

        if (flush) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_d[i]  = '0;
                wptr_d[i] = '0;
                rptr_d[i] = '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                push = src_valid[i] & src_ready[i];
                pop  = grant_vld && (32'(grant_idx) == 32'(i));
                if (push) begin
                    mem_tag_d[i][wptr_q[i]]  = src_tag[i*TAG_W +: TAG_W];
                    mem_data_d[i][wptr_q[i]] = src_data[i*DATA_W +: DATA_W];
                    wptr_d[i] = PTR_W'(wptr_q[i] + 1'b1);
                end
                if (pop) begin
                    rptr_d[i] = PTR_W'(rptr_q[i] + 1'b1);
                end
                case ({push, pop})
                    2'b10:   cnt_d[i] = CNT_W'(cnt_q[i] + 1'b1);
                    2'b01:   cnt_d[i] = CNT_W'(cnt_q[i] - 1'b1);
                    default: cnt_d[i] = cnt_q[i];
                endcase
            end
            if (grant_vld) begin
                cdb_valid_d = 1'b1;
                cdb_tag_d   = mem_tag_q[grant_idx][rptr_q[grant_idx]];
                cdb_data_d  = mem_data_q[grant_idx][rptr_q[grant_idx]];
                cdb_src_d   = grant_idx;
                rr_ptr_d    = SRC_W'((32'(grant_idx) + 32'd1) % NUM_SRC);
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    mem_tag_q[i][j]  <= '0;
                    mem_data_q[i][j] <= '0;
                end
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
        end else begin
            mem_tag_q   <= mem_tag_d;
            mem_data_q  <= mem_data_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// Bench for cdb_broadcast_arbiter: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_cdb_broadcast_arbiter;

    localparam int N  = 4;
    localparam int TW = 3;
    localparam int DW = 4;
    localparam int D  = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic [N-1:0]    src_valid;
    logic [N-1:0]    src_ready;
    logic [N*TW-1:0] src_tag;
    logic [N*DW-1:0] src_data;
    logic            cdb_valid;
    logic [TW-1:0]   cdb_tag;
    logic [DW-1:0]   cdb_data;
    logic [1:0]      cdb_src;

    cdb_broadcast_arbiter #(.NUM_SRC(N), .TAG_W(TW), .DATA_W(DW), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_tag(src_tag), .src_data(src_data),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .cdb_src(cdb_src)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: one queue of {tag,data} per source
    typedef logic [TW+DW-1:0] q_t [$];
    q_t         mq [N];
    int         m_rr = 0;
    logic       m_valid = 1'b0;
    logic [2:0] m_tag = '0;
    logic [3:0] m_data = '0;
    int         m_src = 0;

    bit         col_en = 1'b0;
    logic [3:0] col1 [$];

    // Advance the model on each edge from pre-edge inputs, then compare
    always @(posedge clk) begin
        bit           rdy [N];
        int           g;
        logic [6:0]   e;
        logic [N-1:0] er;
        for (int i = 0; i < N; i++) rdy[i] = (mq[i].size() < D);
        if (!rst_n || flush) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            if (!rst_n) m_rr = 0;
            m_valid = 1'b0; m_tag = '0; m_data = '0; m_src = 0;
        end else begin
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && mq[(m_rr + k) % N].size() > 0) g = (m_rr + k) % N;
            if (g >= 0) begin
                e = mq[g].pop_front();
                m_valid = 1'b1; m_tag = e[6:4]; m_data = e[3:0]; m_src = g;
                m_rr = (g + 1) % N;
            end else begin
                m_valid = 1'b0; m_tag = '0; m_data = '0; m_src = 0;
            end
            for (int i = 0; i < N; i++)
                if (src_valid[i] && rdy[i])
                    mq[i].push_back({src_tag[i*TW +: TW], src_data[i*DW +: DW]});
        end
        #1;
        for (int i = 0; i < N; i++) er[i] = (mq[i].size() < D);
        check("model_valid", 32'(cdb_valid), 32'(m_valid));
        check("model_tag",   32'(cdb_tag),   32'(m_tag));
        check("model_data",  32'(cdb_data),  32'(m_data));
        check("model_src",   32'(cdb_src),   32'(m_src));
        check("model_ready", 32'(src_ready), 32'(er));
        if (col_en && cdb_valid && cdb_src == 2'd1) col1.push_back(cdb_data);
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic set_src(input int i, input logic v, input logic [2:0] t, input logic [3:0] d);
        src_valid[i]         = v;
        src_tag[i*TW +: TW]  = t;
        src_data[i*DW +: DW] = d;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   d0;
        int   sent1;
        int   t3;
        logic acc0, acc1;

        rst_n = 1'b0; flush = 1'b0;
        src_valid = '0; src_tag = '0; src_data = '0;
        tick; tick;
        rst_n = 1'b1;

        // Reset then idle
        repeat (5) begin
            tick;
            check("idle_valid", 32'(cdb_valid), 32'd0);
            check("idle_tag",   32'(cdb_tag),   32'd0);
            check("idle_data",  32'(cdb_data),  32'd0);
            check("idle_ready", 32'(src_ready), 32'hF);
        end

        // Single result: visible two edges after the push
        set_src(2, 1'b1, 3'd5, 4'hA);
        tick;
        src_valid = '0;
        check("single_n1_valid", 32'(cdb_valid), 32'd0);
        tick;
        check("single_valid", 32'(cdb_valid), 32'd1);
        check("single_tag",   32'(cdb_tag),   32'd5);
        check("single_data",  32'(cdb_data),  32'hA);
        check("single_src",   32'(cdb_src),   32'd2);
        check("model_pin_tag", 32'(m_tag),    32'd5);
        check("model_pin_rr",  32'(m_rr),     32'd3);
        tick;
        check("single_after", 32'(cdb_valid), 32'd0);

        // Reset mid-operation discards a queued entry
        set_src(1, 1'b1, 3'd6, 4'h6);
        tick;
        src_valid = '0;
        do_reset;
        check("rst_mid_valid", 32'(cdb_valid), 32'd0);
        tick;
        check("rst_mid_after", 32'(cdb_valid), 32'd0);
        check("model_pin_rr_rst", 32'(m_rr), 32'd0);

        // Round-robin over all four, then sources 0 and 3 only
        for (int i = 0; i < N; i++) set_src(i, 1'b1, 3'(i), 4'(i));
        tick;
        src_valid = '0;
        tick;
        for (int i = 0; i < N; i++) begin
            check("rr_src",  32'(cdb_src),  32'(i));
            check("rr_data", 32'(cdb_data), 32'(i));
            tick;
        end
        set_src(0, 1'b1, 3'd0, 4'h8);
        set_src(3, 1'b1, 3'd3, 4'h9);
        tick;
        src_valid = '0;
        tick;
        check("rr2_first",  32'(cdb_src), 32'd0);
        check("rr2_fdata",  32'(cdb_data), 32'h8);
        tick;
        check("rr2_second", 32'(cdb_src), 32'd3);
        check("rr2_sdata",  32'(cdb_data), 32'h9);
        tick;

        // Backpressure on src1 while src0 keeps a backlog
        col_en = 1'b1;
        d0 = 0; sent1 = 0; t3 = -1;
        set_src(0, 1'b1, 3'd0, 4'(d0));
        set_src(1, 1'b1, 3'd1, 4'd5);
        for (int c = 0; c < 30 && sent1 < 3; c++) begin
            acc0 = src_valid[0] & src_ready[0];
            acc1 = src_valid[1] & src_ready[1];
            tick;
            if (acc0) begin
                d0++;
                set_src(0, 1'b1, 3'(d0), 4'(d0));
            end
            if (acc1) begin
                sent1++;
                if (sent1 == 2) check("bp_ready1_low", 32'(src_ready[1]), 32'd0);
                if (sent1 == 3) t3 = c;
                if (sent1 < 3) set_src(1, 1'b1, 3'd1, 4'(5 + sent1));
                else src_valid[1] = 1'b0;
            end
        end
        src_valid = '0;
        check("bp_all_accepted", 32'(sent1), 32'd3);
        check("bp_third_cycle", 32'(t3), 32'd3);
        repeat (8) tick;
        col_en = 1'b0;
        check("bp_count", 32'(col1.size()), 32'd3);
        if (col1.size() == 3) begin
            check("bp_order0", 32'(col1[0]), 32'd5);
            check("bp_order1", 32'(col1[1]), 32'd6);
            check("bp_order2", 32'(col1[2]), 32'd7);
        end

        // Full FIFO granted while offered: no push, count drops
        do_reset;
        set_src(0, 1'b1, 3'd0, 4'd1);
        set_src(1, 1'b1, 3'd1, 4'd2);
        set_src(2, 1'b1, 3'd2, 4'd3);
        tick;
        src_valid[1] = 1'b0; src_valid[2] = 1'b0;
        set_src(0, 1'b1, 3'd0, 4'd4);
        tick;
        set_src(0, 1'b1, 3'd0, 4'd5);
        tick;
        check("full_ready0_low", 32'(src_ready[0]), 32'd0);
        check("full_src1", 32'(cdb_src), 32'd1);
        check("full_data2", 32'(cdb_data), 32'd2);
        set_src(0, 1'b1, 3'd0, 4'd6);
        tick;
        check("full_ready0_still", 32'(src_ready[0]), 32'd0);
        check("full_src2", 32'(cdb_src), 32'd2);
        tick;
        check("full_pop_src0", 32'(cdb_src), 32'd0);
        check("full_pop_data", 32'(cdb_data), 32'd4);
        check("full_ready0_back", 32'(src_ready[0]), 32'd1);
        tick;
        src_valid = '0;
        repeat (5) tick;

        // Flush mid-stream keeps rr_ptr and drops everything
        do_reset;
        for (int i = 0; i < N; i++) set_src(i, 1'b1, 3'(i + 1), 4'(i + 1));
        tick;
        src_valid = '0;
        tick;
        check("fl_pre_valid", 32'(cdb_valid), 32'd1);
        check("fl_pre_tag",   32'(cdb_tag),   32'd1);
        flush = 1'b1;
        set_src(3, 1'b1, 3'd7, 4'd7);
        tick;
        flush = 1'b0;
        src_valid = '0;
        check("fl_valid", 32'(cdb_valid), 32'd0);
        check("fl_tag",   32'(cdb_tag),   32'd0);
        check("fl_ready", 32'(src_ready), 32'hF);
        repeat (3) begin
            tick;
            check("fl_quiet", 32'(cdb_valid), 32'd0);
        end
        set_src(0, 1'b1, 3'd5, 4'd5);
        set_src(2, 1'b1, 3'd6, 4'd6);
        tick;
        src_valid = '0;
        tick;
        check("fl_rr_first", 32'(cdb_src), 32'd2);
        check("fl_rr_ftag",  32'(cdb_tag), 32'd6);
        tick;
        check("fl_rr_second", 32'(cdb_src), 32'd0);
        check("fl_rr_stag",   32'(cdb_tag), 32'd5);
        tick;
        check("fl_end_idle", 32'(cdb_valid), 32'd0);
        tick;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
